// File: rtl/sisc_fetch_pkg.sv
// rtl/sisc_fetch_pkg.sv - shared types and constants for the SISC fetch sequencer
package sisc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] SISC_NOP     = 32'h0000_0000;
    localparam logic [3:0]  SISC_HALT_OP = 4'hF;

    // Opcode lives in the top OP_W bits of the instruction word
    localparam int OP_W = 4;

    function automatic int op_lsb(input int iw);
        return iw - OP_W;
    endfunction

endpackage

// File: rtl/sisc_prog_mem.sv
// rtl/sisc_prog_mem.sv - program store: one synchronous write port, one combinational read port
module sisc_prog_mem #(
    parameter int DEPTH = 64,
    parameter int IW    = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sisc_fetch.sv
// rtl/sisc_fetch.sv - instruction fetch sequencer for the sisc core; SISC_FETCH_STEP_EN adds single-step inputs
module sisc_fetch
    import sisc_fetch_pkg::*;
#(
    parameter int         IW        = 32,
    parameter int         DEPTH     = 64,
    parameter int         AW        = $clog2(DEPTH),
    parameter int         ISSUE_CYC = 5,
    parameter logic [3:0] HALT_OP   = SISC_HALT_OP
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [IW-1:0] ld_data,
    input  logic          start,
`ifdef SISC_FETCH_STEP_EN
    input  logic          step_mode,
    input  logic          step,
`endif
    output logic [IW-1:0] ir,
    output logic          ir_vld,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    localparam int OP_LSB = op_lsb(IW);
    localparam int CW     = $clog2(ISSUE_CYC + 1);

    fetch_state_t  state, state_nxt;
    logic [CW-1:0] cnt;
    logic [AW-1:0] fetch_addr;
    logic [IW-1:0] rd_data;
    logic          mem_we;
    logic          step_on, step_ok;
    logic          single, hold_go, rd_is_halt, ir_is_halt;

`ifdef SISC_FETCH_STEP_EN
    assign step_on = step_mode;
    assign step_ok = step;
`else
    assign step_on = 1'b0;
    assign step_ok = 1'b0;
`endif

    // fetch_addr runs ahead of pc so pc always names the word on ir
    sisc_prog_mem #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (fetch_addr),
        .rdata (rd_data)
    );

    assign rd_is_halt = (rd_data[IW-1:OP_LSB] == HALT_OP);
    assign ir_is_halt = (ir[IW-1:OP_LSB] == HALT_OP);
    assign single     = (ISSUE_CYC == 1) && !step_on;
    // Free-running leaves on the edge the counter hits 0; stepping waits at 0 for a pulse
    assign hold_go    = step_on ? ((cnt == '0) && step_ok) : (cnt <= CW'(1));

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_HALT: if (start) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (!single)        state_nxt = ST_HOLD;
                else if (rd_is_halt) state_nxt = ST_HALT;
            end
            ST_HOLD: if (hold_go) state_nxt = ir_is_halt ? ST_HALT : ST_ISSUE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ST_ISSUE) || (state == ST_HOLD);
        halted = (state == ST_HALT);
        mem_we = ld_we && !busy;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            ir         <= SISC_NOP[IW-1:0];
            ir_vld     <= 1'b0;
            pc         <= '0;
            fetch_addr <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_ISSUE: begin
                    ir     <= rd_data;
                    ir_vld <= 1'b1;
                    pc     <= fetch_addr;
                    cnt    <= CW'(ISSUE_CYC - 1);
                    if (single && !rd_is_halt) fetch_addr <= fetch_addr + 1'b1;
                end
                ST_HOLD: begin
                    ir_vld <= 1'b0;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    if (hold_go && !ir_is_halt) fetch_addr <= fetch_addr + 1'b1;
                end
                default: begin
                    ir_vld <= 1'b0;
                    if (start) begin
                        pc         <= '0;
                        fetch_addr <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sisc_fetch.sv
// tb/tb_sisc_fetch.sv - self-checking bench for sisc_fetch (default build and ISSUE_CYC=1/DEPTH=4 build)
module tb_sisc_fetch;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        ld_we = 1'b0;
    logic [5:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;

    logic [31:0] ir0, ir1;
    logic        vld0, vld1, busy0, busy1, hlt0, hlt1;
    logic [5:0]  pc0;
    logic [1:0]  pc1;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sisc_fetch u0 (
        .clk(clk), .rst_f(rst_f), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start),
`ifdef SISC_FETCH_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .ir(ir0), .ir_vld(vld0), .pc(pc0), .busy(busy0), .halted(hlt0)
    );

    sisc_fetch #(.DEPTH(4), .ISSUE_CYC(1)) u1 (
        .clk(clk), .rst_f(rst_f), .ld_we(ld_we), .ld_addr(ld_addr[1:0]), .ld_data(ld_data),
        .start(start),
`ifdef SISC_FETCH_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .ir(ir1), .ir_vld(vld1), .pc(pc1), .busy(busy1), .halted(hlt1)
    );

    // Reference model: mode 0 idle, 1 running, 2 halted; t counts edges since start
    int          mode [2];
    int          t    [2];
    logic [31:0] mm   [2][64];
    logic [31:0] e_ir [2];
    int          e_pc [2];
    bit          e_vld[2], e_busy[2], e_hlt[2];

    function automatic int cyc(input int i);
        return (i == 0) ? 5 : 1;
    endfunction

    function automatic int dep(input int i);
        return (i == 0) ? 64 : 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; t[i] = 0; e_ir[i] = 32'h0; e_pc[i] = 0;
            e_vld[i] = 0; e_busy[i] = 0; e_hlt[i] = 0;
        end
    endtask

    task automatic model_step();
        int n, a;
        bit run;
        if (!rst_f) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            run = (mode[i] == 1);
            if (ld_we && !run) mm[i][int'(ld_addr) % dep(i)] = ld_data;
            if (start && !run) begin
                mode[i] = 1; t[i] = 0; e_pc[i] = 0;
                e_busy[i] = 1; e_hlt[i] = 0; e_vld[i] = 0;
            end else if (run) begin
                t[i]++;
                n = (t[i] - 1) / cyc(i);
                a = n % dep(i);
                e_ir[i]  = mm[i][a];
                e_pc[i]  = a;
                e_vld[i] = ((t[i] - 1) % cyc(i)) == 0;
                if (t[i] == cyc(i) * (n + 1) && e_ir[i][31:28] == 4'hF) begin
                    mode[i] = 2; e_busy[i] = 0; e_hlt[i] = 1;
                end
            end else begin
                e_vld[i] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[u%0d] observed=%h expected=%h", tag, i, obs, exp);
    endtask

    task automatic check_all();
        chk("ir", 0, ir0, e_ir[0]);
        chk("ir_vld", 0, 32'(vld0), 32'(e_vld[0]));
        chk("pc", 0, 32'(pc0), 32'(e_pc[0]));
        chk("busy", 0, 32'(busy0), 32'(e_busy[0]));
        chk("halted", 0, 32'(hlt0), 32'(e_hlt[0]));
        chk("ir", 1, ir1, e_ir[1]);
        chk("ir_vld", 1, 32'(vld1), 32'(e_vld[1]));
        chk("pc", 1, 32'(pc1), 32'(e_pc[1]));
        chk("busy", 1, 32'(busy1), 32'(e_busy[1]));
        chk("halted", 1, 32'(hlt1), 32'(e_hlt[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic write_word(input logic [5:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [31:0] prog [4];
    logic [31:0] w;
    int          h;

    initial begin
        prog[0] = 32'h8801_0001; prog[1] = 32'h8011_2001;
        prog[2] = 32'h8022_300B; prog[3] = 32'hF000_0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst_f = 1'b1;
        tick();

        // Default program; a write to address 1 during u0's HOLD is dropped there
        for (int a = 0; a < 4; a++) write_word(6'(a), prog[a]);
        pulse_start();
        for (int c = 0; c < 28; c++) begin
            ld_we = (c == 7); ld_addr = 6'd1; ld_data = 32'h1234_5678;
            tick();
        end
        ld_we = 1'b0;
        chk("halt_word", 0, ir0, 32'hF000_0000);
        chk("halt_flag", 0, 32'(hlt0), 32'd1);

        // Same write while halted is taken and replayed
        write_word(6'd1, 32'h1234_5678);
        pulse_start();
        for (int c = 0; c < 25; c++) tick();
        write_word(6'd1, prog[1]);

        // Asynchronous reset in the middle of a HOLD window
        pulse_start();
        for (int c = 0; c < 7; c++) tick();
        rst_f = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        rst_f = 1'b1;
        pulse_start();
        for (int c = 0; c < 25; c++) tick();
        chk("replay_halt", 0, ir0, 32'hF000_0000);

        // Random program: u0 halts at h, u1 never sees a HALT and wraps forever
        h = $urandom_range(4, 59);
        for (int a = 0; a < 64; a++) begin
            w = $urandom;
            if (w[31:28] == 4'hF) w[31:28] = 4'h8;
            if (a == h) w[31:28] = 4'hF;
            write_word(6'(a), w);
        end
        pulse_start();
        for (int c = 0; c < 5 * (h + 1) + 12; c++) begin
            start   = ($urandom_range(0, 7) == 0);
            ld_we   = ($urandom_range(0, 7) == 0);
            ld_addr = 6'($urandom);
            ld_data = $urandom;
            tick();
        end
        start = 1'b0; ld_we = 1'b0;
        chk("wrap_busy", 1, 32'(busy1), 32'd1);

`ifdef SISC_FETCH_STEP_EN
        // Single-step: word 0 is held until a step pulse after the hold window
        rst_f = 1'b0;
        tick();
        rst_f = 1'b1;
        for (int a = 0; a < 4; a++) write_word(6'(a), prog[a]);
        step_mode = 1'b1;
        pulse_start();
        repeat (30) @(posedge clk);
        #1;
        chk("step_hold", 0, ir0, prog[0]);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("step_adv", 0, ir0, prog[1]);
        chk("step_pc", 0, 32'(pc0), 32'd1);
        step_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
